arbitro_ula: RTL and testbench
==============================

# arbitro_ula

Two-port round-robin arbiter and sequencer that shares a single combinational ULA between two requesters, for example the core datapath and an I/O/DMA unit. It latches the granted requester's operands and drives the ULA from registers. It holds multiply and divide opcodes for a configurable number of extra cycles so those long paths can be treated as multicycle. It then returns a registered result, zero flag, and a one-cycle acknowledge to the served requester.

## Interface
- `LARGURA`, 32: operand/result width.
- `CICLOS_MULTDIV`, 2: extra hold cycles for opcodes 0110 (mult) and 0111 (div); legal range 0..15.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_0` / `req_1` in 1: request, held high until `ack_n` is seen.
- `controle_0` / `controle_1` in 4: ULA opcode.
- `dado1_0` / `dado1_1` in LARGURA: first operand.
- `dado2_0` / `dado2_1` in LARGURA: second operand or immediate.
- `shamt_0` / `shamt_1` in 5: shift amount.
- `ula_dado_1`, `ula_dado_ULA` out LARGURA: registered operands to the ULA.
- `ula_shamt` out 5: registered shift amount to the ULA.
- `ula_controle` out 4: registered opcode to the ULA.
- `ula_resultado` in LARGURA: ULA result.
- `ula_zero` in 1: ULA zero flag.
- `ack_0` / `ack_1` out 1: one-cycle completion pulse.
- `resultado` out LARGURA: registered result of the last completed op.
- `zero` out 1: registered zero flag of the last completed op.
- `ocupado` out 1: high whenever the state is not LIVRE.

## Operation
- **States:**
  - LIVRE: idle.
  - EXECUTA: ULA inputs applied, wait counter running.
  - CONCLUI: `ack` high.
- **LIVRE:**
  - With no request, stay in LIVRE and drive `ula_controle` = 0000.
  - If any `req_n` is high, grant one requester. When both request, `ptr` chooses.
  - Latch that requester's opcode, operands and shamt into the ULA output registers.
  - Load `cnt` = CICLOS_MULTDIV if the opcode is 0110/0111, else 0, then go to EXECUTA.
- **EXECUTA:**
  - If `cnt` ≠ 0, decrement `cnt`.
  - If `cnt` = 0, register `ula_resultado`→`resultado` and `ula_zero`→`zero`, set `ack` of the granted requester, go to CONCLUI.
- **CONCLUI:** clear `ack`, set `ptr` to the other requester, restore `ula_controle` = 0000, go to LIVRE.
- Operand registers keep their last values in LIVRE. Only the opcode is forced to 0000.
- Opcodes are forwarded unchecked. Undefined opcodes complete through the normal path with the ULA default result of 0.
- `resultado`/`zero` hold their value until the next completion.

## Timing
- Reset values:
  - state = LIVRE; `ptr` = 0; `cnt` = 0.
  - all `ula_*` outputs, `resultado`, `zero`, `ack_0`, `ack_1`, `ocupado` = 0.
- Latency is measured from the sampling edge in LIVRE: `ack` is high during cycle 2 + CICLOS_MULTDIV for mult/div, cycle 2 for all other ops. `resultado` is valid in the same cycle as `ack`.
- `ula_*` outputs are stable from the grant edge through the end of CONCLUI.
- **Handshake:**
  - The requester must hold its operands stable while `req` is high.
  - It may drop `req` or present a new request at the edge ending the `ack` cycle. The arbiter samples again only in LIVRE.
  - Minimum spacing between grants is 3 cycles.
- **Fairness:** with both requests held continuously, grants alternate 0,1,0,1.
- Dropping `req` before grant has no effect. Dropping it after grant still lets the op complete, and the `ack` still pulses.
- Reset asserted mid-operation:
  - Immediate return to the reset values.
  - The aborted request receives no `ack` and must be re-issued.

## Structure
- Shared package `ula_pkg`:
  - opcode constants: OP_NOP=0000, OP_ADD=0100, OP_SUB=0101, OP_MULT=0110, OP_DIV=0111, OP_BEQ=1100.
  - state encoding: LIVRE, EXECUTA, CONCLUI.
- No sub-module. The ULA is instantiated beside this block by the parent.
- The round-robin pick is inline logic.

## Test plan
- Reset pulse mid-idle → all outputs 0, `ocupado` = 0, `ula_controle` = 0000.
- `req_0` only, 0100, `dado1_0` = 5, `dado2_0` = −3 → `ack_0` in cycle 2, `resultado` = 2, `zero` = 0; `ack_1` never rises.
- `req_0` (0101, 10−10) and `req_1` (1100, 7,7) asserted together after reset:
  - requester 0 served first with `resultado` = 0, `zero` = 0;
  - then requester 1 with `resultado` = 1, `zero` = 1.
- CICLOS_MULTDIV = 2, `req_1` 0110 with 6×7 → `ack_1` in cycle 4, `resultado` = 42; `ula_*` outputs constant over all 4 cycles.
- 0111 with `dado2` = 0 → `ack` in cycle 4, `resultado` = 0; both requests held continuously for 6 grants → grant order alternates.
- `reset` asserted in EXECUTA of a mult → no `ack`, `ocupado` = 0 immediately; the re-issued request completes normally with `ptr` = 0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode helpers for the
// ULA arbiter.
package ula_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_MULT = 4'b0110;
    localparam logic [3:0] OP_DIV  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1100;

    typedef enum logic [1:0] {
        LIVRE   = 2'd0,
        EXECUTA = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    // Multiply and divide are the long ULA paths that get extra hold cycles.
    function automatic logic eh_multdiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/arbitro_ula.sv
// Round-robin arbiter/sequencer sharing one combinational ULA between two
// requesters; operands and results are registered on both sides of the ULA.
module arbitro_ula
    import ula_pkg::*;
#(
    parameter int LARGURA        = 32,
    parameter int CICLOS_MULTDIV = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_0,
    input  logic               req_1,
    input  logic [3:0]         controle_0,
    input  logic [3:0]         controle_1,
    input  logic [LARGURA-1:0] dado1_0,
    input  logic [LARGURA-1:0] dado1_1,
    input  logic [LARGURA-1:0] dado2_0,
    input  logic [LARGURA-1:0] dado2_1,
    input  logic [4:0]         shamt_0,
    input  logic [4:0]         shamt_1,
    output logic [LARGURA-1:0] ula_dado_1,
    output logic [LARGURA-1:0] ula_dado_ULA,
    output logic [4:0]         ula_shamt,
    output logic [3:0]         ula_controle,
    input  logic [LARGURA-1:0] ula_resultado,
    input  logic               ula_zero,
    output logic               ack_0,
    output logic               ack_1,
    output logic [LARGURA-1:0] resultado,
    output logic               zero,
    output logic               ocupado
);

    localparam logic [3:0] CNT_MULTDIV = 4'(CICLOS_MULTDIV);

    estado_t            estado_q, estado_d;
    logic               ptr_q, ptr_d;
    logic               gnt_q, gnt_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [LARGURA-1:0] dado1_q, dado1_d;
    logic [LARGURA-1:0] dado2_q, dado2_d;
    logic [4:0]         shamt_q, shamt_d;
    logic [3:0]         controle_q, controle_d;
    logic [LARGURA-1:0] resultado_q, resultado_d;
    logic               zero_q, zero_d;
    logic [1:0]         ack_q, ack_d;

    // Round-robin pick: ptr only matters when both requesters contend.
    logic               sel;
    logic [3:0]         op_sel;
    assign sel    = (req_0 && req_1) ? ptr_q : req_1;
    assign op_sel = sel ? controle_1 : controle_0;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the case below can infer a latch.
        estado_d    = estado_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        dado1_d     = dado1_q;
        dado2_d     = dado2_q;
        shamt_d     = shamt_q;
        controle_d  = controle_q;
        resultado_d = resultado_q;
        zero_d      = zero_q;
        ack_d       = 2'b00;

        case (estado_q)
            LIVRE: begin
                controle_d = OP_NOP;
                if (req_0 || req_1) begin
                    gnt_d      = sel;
                    controle_d = op_sel;
                    dado1_d    = sel ? dado1_1 : dado1_0;
                    dado2_d    = sel ? dado2_1 : dado2_0;
                    shamt_d    = sel ? shamt_1 : shamt_0;
                    cnt_d      = eh_multdiv(op_sel) ? CNT_MULTDIV : 4'd0;
                    estado_d   = EXECUTA;
                end
            end
            EXECUTA: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resultado_d = ula_resultado;
                    zero_d      = ula_zero;
                    ack_d       = gnt_q ? 2'b10 : 2'b01;
                    estado_d    = CONCLUI;
                end
            end
            CONCLUI: begin
                ptr_d      = ~gnt_q;
                controle_d = OP_NOP;
                estado_d   = LIVRE;
            end
            default: estado_d = LIVRE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values computed before this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= LIVRE;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            cnt_q       <= 4'd0;
            dado1_q     <= '0;
            dado2_q     <= '0;
            shamt_q     <= '0;
            controle_q  <= OP_NOP;
            resultado_q <= '0;
            zero_q      <= 1'b0;
            ack_q       <= 2'b00;
        end else begin
            estado_q    <= estado_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            dado1_q     <= dado1_d;
            dado2_q     <= dado2_d;
            shamt_q     <= shamt_d;
            controle_q  <= controle_d;
            resultado_q <= resultado_d;
            zero_q      <= zero_d;
            ack_q       <= ack_d;
        end
    end

    assign ula_dado_1   = dado1_q;
    assign ula_dado_ULA = dado2_q;
    assign ula_shamt    = shamt_q;
    assign ula_controle = controle_q;
    assign resultado    = resultado_q;
    assign zero         = zero_q;
    assign ack_0        = ack_q[0];
    assign ack_1        = ack_q[1];
    assign ocupado      = (estado_q != LIVRE);

endmodule

// File: tb/tb_arbitro_ula.sv
// Self-checking bench for arbitro_ula: a behavioural ULA sits beside the DUT
// and a spec-level model predicts grant order, latency, result and zero flag.
module tb_arbitro_ula;
    import ula_pkg::*;

    localparam int W = 32;
    localparam int C = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_0, req_1;
    logic [3:0]   controle_0, controle_1;
    logic [W-1:0] dado1_0, dado1_1, dado2_0, dado2_1;
    logic [4:0]   shamt_0, shamt_1;
    logic [W-1:0] ula_dado_1, ula_dado_ULA, ula_resultado, resultado;
    logic [4:0]   ula_shamt;
    logic [3:0]   ula_controle;
    logic         ula_zero, ack_0, ack_1, zero, ocupado;

    int n_checks = 0;
    int n_fail   = 0;
    int ack0_seen = 0;
    int ack1_seen = 0;

    always #5 clock = ~clock;

    arbitro_ula #(.LARGURA(W), .CICLOS_MULTDIV(C)) dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .req_1(req_1),
        .controle_0(controle_0), .controle_1(controle_1),
        .dado1_0(dado1_0), .dado1_1(dado1_1),
        .dado2_0(dado2_0), .dado2_1(dado2_1),
        .shamt_0(shamt_0), .shamt_1(shamt_1),
        .ula_dado_1(ula_dado_1), .ula_dado_ULA(ula_dado_ULA),
        .ula_shamt(ula_shamt), .ula_controle(ula_controle),
        .ula_resultado(ula_resultado), .ula_zero(ula_zero),
        .ack_0(ack_0), .ack_1(ack_1),
        .resultado(resultado), .zero(zero), .ocupado(ocupado)
    );

    // Reference arithmetic for the ops this ULA understands; anything else yields 0.
    function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MULT: return a * b;
            OP_DIV:  return (b == 0) ? '0 : a / b;
            OP_BEQ:  return (a == b) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_zero(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        return (op == OP_BEQ) && (a == b);
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return (op == OP_MULT || op == OP_DIV) ? 2 + C : 2;
    endfunction

    function automatic logic [3:0] pick_op();
        logic [3:0] ops [6] = '{OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_BEQ, 4'b0011};
        return ops[$urandom_range(0, 5)];
    endfunction

    always_comb begin
        ula_resultado = ref_res(ula_controle, ula_dado_1, ula_dado_ULA);
        ula_zero      = ref_zero(ula_controle, ula_dado_1, ula_dado_ULA);
    end

    always @(negedge clock) begin
        if (ack_0) ack0_seen++;
        if (ack_1) ack1_seen++;
    end

    task automatic drive(input int r, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh);
        if (r == 0) begin
            controle_0 = op; dado1_0 = a; dado2_0 = b; shamt_0 = sh;
        end else begin
            controle_1 = op; dado1_1 = a; dado2_1 = b; shamt_1 = sh;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (ocupado && n < 20) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
    endtask

    // Single requester: latency, grant, result, operand stability, return to idle.
    task automatic run_op(input int r, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh, input string name);
        int  cyc = 0;
        bit  stable = 1'b1;
        wait_idle();
        drive(r, op, a, b, sh);
        if (r == 0) req_0 = 1'b1; else req_1 = 1'b1;
        @(posedge clock);
        while (cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (ula_controle !== op || ula_dado_1 !== a || ula_dado_ULA !== b || ula_shamt !== sh)
                stable = 1'b0;
            if (ack_0 || ack_1) break;
        end
        n_checks++;
        if (cyc !== ref_lat(op)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, ref_lat(op));
        end
        n_checks++;
        if ({ack_1, ack_0} !== ((r == 1) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL %s ack: got {ack_1,ack_0}=%b, expected requester %0d", name, {ack_1, ack_0}, r);
        end
        n_checks++;
        if (resultado !== ref_res(op, a, b) || zero !== ref_zero(op, a, b)) begin
            n_fail++;
            $display("FAIL %s result: got %h/z%b, expected %h/z%b", name, resultado, zero,
                     ref_res(op, a, b), ref_zero(op, a, b));
        end
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL %s ula_stable: ULA inputs changed between grant and ack (now op %h a %h b %h)",
                     name, ula_controle, ula_dado_1, ula_dado_ULA);
        end
        if (r == 0) req_0 = 1'b0; else req_1 = 1'b0;
        @(negedge clock);
        n_checks++;
        if (ack_0 !== 1'b0 || ack_1 !== 1'b0 || ocupado !== 1'b0 || ula_controle !== OP_NOP) begin
            n_fail++;
            $display("FAIL %s release: ack=%b%b ocupado=%b controle=%h, expected 0 0 0 0000",
                     name, ack_1, ack_0, ocupado, ula_controle);
        end
    endtask

    // Both requests held; k grants must alternate starting with 'first'. After
    // each ack the served requester presents a fresh random op.
    task automatic run_pair(input int k, input int first,
                            input logic [3:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input logic [3:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                            input string name);
        logic [3:0]   p_op [2];
        logic [W-1:0] p_a [2];
        logic [W-1:0] p_b [2];
        int exp_who = first;
        int exp_gap;
        int cyc;
        p_op[0] = op0; p_a[0] = a0; p_b[0] = b0;
        p_op[1] = op1; p_a[1] = a1; p_b[1] = b1;
        wait_idle();
        drive(0, op0, a0, b0, 5'd0);
        drive(1, op1, a1, b1, 5'd0);
        req_0 = 1'b1;
        req_1 = 1'b1;
        @(posedge clock);
        exp_gap = ref_lat(p_op[exp_who]);
        for (int g = 0; g < k; g++) begin
            cyc = 0;
            while (cyc < 40) begin
                @(negedge clock);
                cyc++;
                if (ack_0 || ack_1) break;
            end
            n_checks++;
            if ({ack_1, ack_0} !== ((exp_who == 1) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL %s grant%0d: got {ack_1,ack_0}=%b, expected requester %0d",
                         name, g, {ack_1, ack_0}, exp_who);
            end
            n_checks++;
            if (cyc !== exp_gap) begin
                n_fail++;
                $display("FAIL %s gap%0d: got %0d cycles, expected %0d", name, g, cyc, exp_gap);
            end
            n_checks++;
            if (resultado !== ref_res(p_op[exp_who], p_a[exp_who], p_b[exp_who]) ||
                zero !== ref_zero(p_op[exp_who], p_a[exp_who], p_b[exp_who])) begin
                n_fail++;
                $display("FAIL %s result%0d: got %h/z%b, expected %h/z%b", name, g, resultado, zero,
                         ref_res(p_op[exp_who], p_a[exp_who], p_b[exp_who]),
                         ref_zero(p_op[exp_who], p_a[exp_who], p_b[exp_who]));
            end
            p_op[exp_who] = pick_op();
            p_a[exp_who]  = $urandom_range(0, 1000);
            p_b[exp_who]  = $urandom_range(0, 20);
            drive(exp_who, p_op[exp_who], p_a[exp_who], p_b[exp_who], 5'd0);
            exp_who = 1 - exp_who;
            exp_gap = 1 + ref_lat(p_op[exp_who]);
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset(input string name);
        n_checks++;
        if (ocupado !== 1'b0 || ack_0 !== 1'b0 || ack_1 !== 1'b0 || zero !== 1'b0 || resultado !== '0) begin
            n_fail++;
            $display("FAIL %s status: ocupado=%b ack=%b%b zero=%b resultado=%h, expected all 0",
                     name, ocupado, ack_1, ack_0, zero, resultado);
        end
        n_checks++;
        if (ula_controle !== OP_NOP || ula_dado_1 !== '0 || ula_dado_ULA !== '0 || ula_shamt !== '0) begin
            n_fail++;
            $display("FAIL %s ula: controle=%h d1=%h d2=%h shamt=%h, expected all 0",
                     name, ula_controle, ula_dado_1, ula_dado_ULA, ula_shamt);
        end
    endtask

    task automatic test_single_add();
        int a1 = ack1_seen;
        run_op(0, OP_ADD, 32'd5, 32'hFFFF_FFFD, 5'd3, "add_5_m3");
        n_checks++;
        if (resultado !== 32'd2 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL add_value: got %h/z%b, expected 2/z0", resultado, zero);
        end
        n_checks++;
        if (ack1_seen !== a1) begin
            n_fail++;
            $display("FAIL add_no_ack1: ack_1 pulsed %0d times, expected 0", ack1_seen - a1);
        end
    endtask

    task automatic test_reset_idle();
        wait_idle();
        drive(0, OP_ADD, 32'd9, 32'd9, 5'd7);
        @(negedge clock);
        reset = 1'b1;
        #1;
        test_reset("reset_idle");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_multdiv();
        run_op(1, OP_MULT, 32'd6, 32'd7, 5'd1, "mult_6x7");
        n_checks++;
        if (resultado !== 32'd42) begin
            n_fail++;
            $display("FAIL mult_value: got %0d, expected 42", resultado);
        end
        run_op(0, OP_DIV, 32'd77, 32'd0, 5'd0, "div_by_0");
        run_op(1, 4'b1111, 32'd3, 32'd4, 5'd2, "undef_op");
    endtask

    task automatic test_reset_mid_op();
        int a0 = ack0_seen;
        int a1 = ack1_seen;
        pulse_reset(1);
        run_op(0, OP_ADD, 32'd100, 32'd23, 5'd0, "pre_abort");
        a0 = ack0_seen;
        wait_idle();
        drive(1, OP_MULT, 32'd11, 32'd13, 5'd4);
        req_1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        test_reset("reset_mid_op");
        req_1 = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (ack1_seen !== a1 || ack0_seen !== a0) begin
            n_fail++;
            $display("FAIL abort_no_ack: acks seen %0d/%0d, expected none", ack0_seen - a0, ack1_seen - a1);
        end
        run_pair(2, 0, OP_SUB, 32'd50, 32'd8, OP_MULT, 32'd11, 32'd13, "reissue");
    endtask

    initial begin
        reset = 1'b1;
        req_0 = 1'b0;
        req_1 = 1'b0;
        drive(0, OP_NOP, '0, '0, '0);
        drive(1, OP_NOP, '0, '0, '0);
        repeat (3) @(negedge clock);
        test_reset("reset_init");
        reset = 1'b0;
        @(negedge clock);
        test_reset("after_release");

        test_single_add();
        test_reset_idle();
        run_pair(2, 0, OP_SUB, 32'd10, 32'd10, OP_BEQ, 32'd7, 32'd7, "simultaneous");
        test_multdiv();
        pulse_reset(1);
        run_pair(6, 0, pick_op(), $urandom_range(0, 1000), $urandom_range(0, 20),
                 pick_op(), $urandom_range(0, 1000), $urandom_range(0, 20), "fairness");
        test_reset_mid_op();
        for (int i = 0; i < 8; i++)
            run_op(int'($urandom_range(0, 1)), pick_op(), $urandom, $urandom,
                   5'($urandom_range(0, 31)), "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
